// File: rtl/bcd_scan_display_pkg.sv
// bcd_scan_display_pkg: segment patterns and default sizing for the scanned BCD display
package bcd_scan_display_pkg;
  localparam int N_DIG_DEF = 4;
  localparam int DIV_DEF = 1000;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/bcd_scan_display_seg7_decode.sv
// seg7_decode: BCD code to {g,f,e,d,c,b,a}; non-decimal codes render as a dash
module seg7_decode
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  assign seg = code > 4'd9 ? SEG_DASH : SEG_DIGITS[code];
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: snapshots packed BCD digits and scans them onto a shared 7-segment bus
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int N_DIG = N_DIG_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic               CP,
  input  logic               CLR,
  input  logic [4*N_DIG-1:0] DIN,
  input  logic               LATCH,
  input  logic               BLANK_EN,
  output logic [6:0]         SEG,
  output logic [N_DIG-1:0]   SEL,
  output logic               BAD
);
  localparam int IW = $clog2(N_DIG);
  logic [4*N_DIG-1:0] snap;
  logic [15:0] pcnt;
  logic [IW-1:0] idx;
  logic [N_DIG-1:0] live;
  logic [3:0] cur;
  logic [6:0] dec;
  logic tick, blank, din_bad, acc;
  assign tick = pcnt == 16'(DIV - 1);
  assign cur = snap[4*idx +: 4];
  assign blank = BLANK_EN && idx != '0 && !live[idx];
  // live[k]: some digit at or above k is non-zero, so digit k must stay lit
  always_comb begin
    acc = 1'b0;
    live = '0;
    din_bad = 1'b0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      acc = acc | (|snap[4*k +: 4]);
      live[k] = acc;
      din_bad = din_bad | (DIN[4*k +: 4] > 4'd9);
    end
  end
  seg7_decode u_dec (
    .code(cur),
    .seg (dec)
  );
  always_ff @(posedge CP or posedge CLR) begin
    if (CLR) begin
      snap <= '0;
      BAD  <= 1'b0;
      pcnt <= '0;
      idx  <= '0;
      SEG  <= SEG_OFF;
      SEL  <= '1;
    end else begin
      if (LATCH) begin
        snap <= DIN;
        BAD  <= din_bad;
      end
      pcnt <= tick ? '0 : pcnt + 16'd1;
      if (tick) idx <= idx == IW'(N_DIG - 1) ? '0 : idx + 1'b1;
      SEL <= ~(N_DIG'(1) << idx);
      SEG <= blank ? SEG_OFF : dec;
    end
  end
endmodule
